// File: rtl/subservient_sram_arbiter.sv
// Two-master Wishbone-classic to byte-wide SRAM arbiter.
// Each word access is split into four byte cycles, then acked.
module subservient_sram_arbiter #(
  parameter int memsize = 512,
  parameter int aw      = $clog2(memsize)
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic [aw-1:0] i_wb_m0_adr,
  input  logic [31:0]   i_wb_m0_dat,
  input  logic [3:0]    i_wb_m0_sel,
  input  logic          i_wb_m0_we,
  input  logic          i_wb_m0_stb,
  output logic [31:0]   o_wb_m0_rdt,
  output logic          o_wb_m0_ack,
  input  logic [aw-1:0] i_wb_m1_adr,
  input  logic [31:0]   i_wb_m1_dat,
  input  logic [3:0]    i_wb_m1_sel,
  input  logic          i_wb_m1_we,
  input  logic          i_wb_m1_stb,
  output logic [31:0]   o_wb_m1_rdt,
  output logic          o_wb_m1_ack,
  output logic [aw-1:0] o_sram_waddr,
  output logic [7:0]    o_sram_wdata,
  output logic          o_sram_wen,
  output logic [aw-1:0] o_sram_raddr,
  input  logic [7:0]    i_sram_rdata,
  output logic          o_sram_ren,
  output logic          o_grant
);

  typedef enum logic [1:0] {
    IDLE, READ, WRITE, ACK
  } state_e;

  state_e        state_q, state_d;
  logic [2:0]    cnt_q, cnt_d;
  logic          grant_q, grant_d;
  logic [aw-3:0] word_q, word_d;
  logic [31:0]   dat_q, dat_d;
  logic [3:0]    sel_q, sel_d;
  logic [31:0]   rdt0_q, rdt0_d;
  logic [31:0]   rdt1_q, rdt1_d;

  logic          req;
  logic          pick;
  logic [1:0]    bidx;
  logic          unused;

  assign unused = ^{i_wb_m0_adr[1:0], i_wb_m1_adr[1:0]};

  assign req  = i_wb_m0_stb | i_wb_m1_stb;
  // Under contention the master that did not win last time goes next.
  assign pick = (i_wb_m0_stb & i_wb_m1_stb) ? ~grant_q
                                            : i_wb_m1_stb;
  // Read data lags the address by one cycle.
  assign bidx = cnt_q[1:0] - 2'd1;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      grant_q <= 1'b1;
      word_q  <= '0;
      dat_q   <= '0;
      sel_q   <= '0;
      rdt0_q  <= '0;
      rdt1_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      grant_q <= grant_d;
      word_q  <= word_d;
      dat_q   <= dat_d;
      sel_q   <= sel_d;
      rdt0_q  <= rdt0_d;
      rdt1_q  <= rdt1_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    grant_d     = grant_q;
    word_d      = word_q;
    dat_d       = dat_q;
    sel_d       = sel_q;
    rdt0_d      = rdt0_q;
    rdt1_d      = rdt1_q;
    o_sram_ren  = 1'b0;
    o_sram_wen  = 1'b0;
    o_wb_m0_ack = 1'b0;
    o_wb_m1_ack = 1'b0;
    unique case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (req) begin
          grant_d = pick;
          if (pick) begin
            word_d  = i_wb_m1_adr[aw-1:2];
            dat_d   = i_wb_m1_dat;
            sel_d   = i_wb_m1_sel;
            state_d = i_wb_m1_we ? WRITE : READ;
          end else begin
            word_d  = i_wb_m0_adr[aw-1:2];
            dat_d   = i_wb_m0_dat;
            sel_d   = i_wb_m0_sel;
            state_d = i_wb_m0_we ? WRITE : READ;
          end
        end
      end
      READ: begin
        o_sram_ren = ~cnt_q[2];
        cnt_d      = cnt_q + 3'd1;
        if (cnt_q != 3'd0) begin
          if (grant_q)
            rdt1_d[{bidx, 3'b000} +: 8] = i_sram_rdata;
          else
            rdt0_d[{bidx, 3'b000} +: 8] = i_sram_rdata;
        end
        if (cnt_q[2])
          state_d = ACK;
      end
      WRITE: begin
        o_sram_wen = sel_q[cnt_q[1:0]];
        cnt_d      = cnt_q + 3'd1;
        if (cnt_q[1:0] == 2'd3)
          state_d = ACK;
      end
      ACK: begin
        o_wb_m0_ack = ~grant_q;
        o_wb_m1_ack = grant_q;
        cnt_d       = '0;
        state_d     = IDLE;
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  assign o_sram_waddr = {word_q, cnt_q[1:0]};
  assign o_sram_raddr = {word_q, cnt_q[1:0]};
  assign o_sram_wdata = dat_q[{cnt_q[1:0], 3'b000} +: 8];
  assign o_wb_m0_rdt  = rdt0_q;
  assign o_wb_m1_rdt  = rdt1_q;
  assign o_grant      = grant_q;

endmodule

// File: tb/tb_subservient_sram_arbiter.sv
// Random and directed bench for subservient_sram_arbiter,
// checked against a word-level memory and arbitration model.
module tb_subservient_sram_arbiter;

  logic        clk;
  logic        rst;
  logic [8:0]  m0_adr, m1_adr;
  logic [31:0] m0_dat, m1_dat;
  logic [3:0]  m0_sel, m1_sel;
  logic        m0_we, m1_we;
  logic        m0_stb, m1_stb;
  logic [31:0] m0_rdt, m1_rdt;
  logic        ack0, ack1;
  logic [8:0]  waddr, raddr;
  logic [7:0]  wdata, rdata;
  logic        wen, ren;
  logic        grant;

  int n_cmp = 0;
  int n_bad = 0;

  subservient_sram_arbiter #(.memsize(512)) dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_wb_m0_adr  (m0_adr),
    .i_wb_m0_dat  (m0_dat),
    .i_wb_m0_sel  (m0_sel),
    .i_wb_m0_we   (m0_we),
    .i_wb_m0_stb  (m0_stb),
    .o_wb_m0_rdt  (m0_rdt),
    .o_wb_m0_ack  (ack0),
    .i_wb_m1_adr  (m1_adr),
    .i_wb_m1_dat  (m1_dat),
    .i_wb_m1_sel  (m1_sel),
    .i_wb_m1_we   (m1_we),
    .i_wb_m1_stb  (m1_stb),
    .o_wb_m1_rdt  (m1_rdt),
    .o_wb_m1_ack  (ack1),
    .o_sram_waddr (waddr),
    .o_sram_wdata (wdata),
    .o_sram_wen   (wen),
    .o_sram_raddr (raddr),
    .i_sram_rdata (rdata),
    .o_sram_ren   (ren),
    .o_grant      (grant)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] pat(input int i);
    return 8'(i * 37 + 5);
  endfunction

  // Behavioural SRAM with registered read port
  logic [7:0] mem [512];
  logic       fill;
  always @(posedge clk) begin
    if (fill) begin
      for (int i = 0; i < 512; i++) mem[i] <= pat(i);
    end else if (wen) begin
      mem[waddr] <= wdata;
    end
    if (ren) rdata <= mem[raddr];
  end

  // Reference model: byte image and last read word per master
  logic [7:0]  refm [512];
  logic [31:0] exp_rdt [2];

  function automatic logic [31:0] refw(input logic [8:0] b);
    return {refm[b + 3], refm[b + 2], refm[b + 1], refm[b]};
  endfunction

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic drive(input bit m, input bit we,
                       input logic [8:0] adr,
                       input logic [31:0] dat,
                       input logic [3:0] sel);
    if (m) begin
      m1_adr = adr; m1_dat = dat; m1_sel = sel;
      m1_we = we; m1_stb = 1'b1;
    end else begin
      m0_adr = adr; m0_dat = dat; m0_sel = sel;
      m0_we = we; m0_stb = 1'b1;
    end
  endtask

  task automatic txn(input bit m, input bit we,
                     input logic [8:0] adr,
                     input logic [31:0] dat,
                     input logic [3:0] sel);
    logic [8:0] b;
    logic [1:0] k;
    int  lat;
    bit  got;
    bit  inw;
    b = {adr[8:2], 2'b00};
    @(posedge clk);
    #1;
    drive(m, we, adr, dat, sel);
    got = 1'b0;
    lat = 0;
    for (int c = 0; c < 20 && !got; c++) begin
      @(negedge clk);
      k   = 2'(c - 1);
      inw = (c >= 1 && c <= 4);
      check("excl", 32'(ren & wen), 32'd0);
      check("ack_other", 32'(m ? ack0 : ack1), 32'd0);
      if (we) begin
        check("ren_in_wr", 32'(ren), 32'd0);
        check("wen", 32'(wen), 32'(inw && sel[k]));
        if (wen) begin
          check("waddr", 32'(waddr), 32'({b[8:2], k}));
          check("wdata", 32'(wdata), 32'(dat[8*k +: 8]));
        end
      end else begin
        check("wen_in_rd", 32'(wen), 32'd0);
        check("ren", 32'(ren), 32'(inw));
        if (ren)
          check("raddr", 32'(raddr), 32'({b[8:2], k}));
      end
      if (m ? ack1 : ack0) begin
        got = 1'b1;
        lat = c;
      end
    end
    m0_stb = 1'b0;
    m1_stb = 1'b0;
    if (!got) begin
      check("ack_timeout", 32'd0, 32'd1);
    end else begin
      check("latency", 32'(lat), we ? 32'd5 : 32'd6);
      check("grant", 32'(grant), 32'(m));
      if (we) begin
        for (int i = 0; i < 4; i++)
          if (sel[i]) refm[b + 9'(i)] = dat[8*i +: 8];
      end else begin
        exp_rdt[m] = refw(b);
      end
      check("rdt0", m0_rdt, exp_rdt[0]);
      check("rdt1", m1_rdt, exp_rdt[1]);
    end
  endtask

  task automatic reset_checks(input string tag);
    check({tag, "_grant"}, 32'(grant), 32'd1);
    check({tag, "_ack"}, 32'({ack0, ack1}), 32'd0);
    check({tag, "_rw"}, 32'({ren, wen}), 32'd0);
    check({tag, "_addr"}, 32'({waddr, raddr}), 32'd0);
    check({tag, "_wdata"}, 32'(wdata), 32'd0);
    check({tag, "_rdt0"}, m0_rdt, 32'd0);
    check({tag, "_rdt1"}, m1_rdt, 32'd0);
  endtask

  initial begin
    int m;
    int n;
    int cyc;
    int last;
    rst = 1'b1;
    fill = 1'b1;
    m0_adr = '0; m0_dat = '0; m0_sel = '0;
    m0_we = 1'b0; m0_stb = 1'b0;
    m1_adr = '0; m1_dat = '0; m1_sel = '0;
    m1_we = 1'b0; m1_stb = 1'b0;
    for (int i = 0; i < 512; i++) refm[i] = pat(i);
    exp_rdt[0] = '0;
    exp_rdt[1] = '0;
    repeat (2) @(posedge clk);
    #1 fill = 1'b0;
    @(negedge clk);
    reset_checks("rst");
    rst = 1'b0;

    // Directed scenarios
    txn(0, 1, 9'h010, 32'hA1B2C3D4, 4'hF);
    txn(0, 0, 9'h012, 32'h0, 4'h0);
    check("tp_rd_m0", m0_rdt, 32'hA1B2C3D4);
    txn(1, 1, 9'h020, 32'hFFFFFFFF, 4'hF);
    txn(1, 1, 9'h020, 32'h11223344, 4'b0101);
    txn(1, 0, 9'h020, 32'h0, 4'h0);
    check("tp_rd_m1", m1_rdt, 32'hFF22FF44);
    txn(0, 1, 9'h030, 32'hDEADBEEF, 4'h0);
    txn(0, 0, 9'h030, 32'h0, 4'h0);

    // Contention from reset: round-robin starting with m0
    @(negedge clk);
    rst = 1'b1;
    exp_rdt[0] = '0;
    exp_rdt[1] = '0;
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    drive(0, 0, 9'h011, 32'h0, 4'h0);
    drive(1, 0, 9'h022, 32'h0, 4'h0);
    m = 0;
    n = 0;
    cyc = 0;
    last = -1;
    while (n < 4 && cyc < 60) begin
      @(negedge clk);
      if (ack0 | ack1) begin
        check("rr_ack", 32'({ack0, ack1}), m ? 32'd1 : 32'd2);
        check("rr_grant", 32'(grant), 32'(m));
        if (last >= 0)
          check("rr_gap", 32'(cyc - last), 32'd7);
        exp_rdt[m] = refw(m ? 9'h020 : 9'h010);
        check("rr_rdt0", m0_rdt, exp_rdt[0]);
        check("rr_rdt1", m1_rdt, exp_rdt[1]);
        last = cyc;
        m ^= 1;
        n++;
      end
      cyc++;
    end
    if (n < 4) check("rr_timeout", 32'(n), 32'd4);
    m0_stb = 1'b0;
    m1_stb = 1'b0;
    repeat (2) @(negedge clk);

    // Reset while a read is in byte cycle 2
    @(posedge clk);
    #1;
    drive(0, 0, 9'h040, 32'h0, 4'h0);
    repeat (4) @(negedge clk);
    check("pre_rst_ren", 32'(ren), 32'd1);
    rst = 1'b1;
    #1;
    exp_rdt[0] = '0;
    exp_rdt[1] = '0;
    reset_checks("mid");
    m0_stb = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check("no_ack", 32'({ack0, ack1}), 32'd0);
    end
    txn(0, 0, 9'h040, 32'h0, 4'h0);
    txn(1, 1, 9'h044, 32'h5A5A0FF0, 4'hF);

    // Randomized traffic against the reference model
    for (int i = 0; i < 80; i++) begin
      txn(1'($urandom_range(0, 1)),
          1'($urandom_range(0, 1)),
          9'($urandom_range(0, 511)),
          $urandom,
          4'($urandom_range(0, 15)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
